// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and default parameters for the UART transmit arbiter
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        ACK,
        EVAL
    } state_t;
    localparam int NREQ_DEF      = 4;
    localparam int BURST_MAX_DEF = 4;
    localparam int TIMEOUT_DEF   = 15;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; one-hot winner is the first set req bit above last_winner, with wrap
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_winner,
    output logic [NREQ-1:0] winner
);
    // Scan lowest priority first so the highest-priority hit overwrites the rest
    always_comb begin
        winner = '0;
        for (int i = NREQ; i >= 1; i--)
            if (req[IW'((int'(last_winner) + i) % NREQ)]) winner = NREQ'(1) << ((int'(last_winner) + i) % NREQ);
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among byte requesters,
// with bounded bursts and a sticky error when the transmitter fails to start.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              baud_clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t          state;
    logic [IW-1:0]   last_winner;
    logic [IW-1:0]   owner;
    logic [BW-1:0]   burst_cnt;
    logic [TW-1:0]   timer;
    logic            last_q;
    logic [NREQ-1:0] winner;
    logic [7:0]      lane [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign lane[g] = req_data[8*g +: 8];
    end
    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req         (req),
        .last_winner (last_winner),
        .winner      (winner)
    );
    always_comb begin
        owner = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) owner = IW'(i);
    end
    assign busy = |grant;
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            timeout_err <= 1'b0;
            burst_cnt   <= '0;
            timer       <= '0;
            last_q      <= 1'b0;
            last_winner <= IW'(NREQ - 1);
        end else begin
            // A timeout set later in this block overrides a simultaneous clear
            if (err_clr) timeout_err <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    grant <= winner;
                    state <= GRANT;
                end
                GRANT: begin
                    tx_data     <= lane[owner];
                    last_q      <= req_last[owner];
                    burst_cnt   <= BW'(1);
                    last_winner <= owner;
                    tx_start    <= 1'b1;
                    state       <= LAUNCH;
                end
                LAUNCH: begin
                    tx_start <= 1'b0;
                    timer    <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: if (tx_busy) begin
                    state <= WAIT_DONE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    timeout_err <= 1'b1;
                    grant       <= '0;
                    state       <= IDLE;
                end else begin
                    timer <= timer + 1'b1;
                end
                WAIT_DONE: if (!tx_busy) begin
                    ack   <= grant;
                    state <= ACK;
                end
                ACK: begin
                    ack   <= '0;
                    state <= EVAL;
                end
                EVAL: if (req[owner] && !last_q && burst_cnt < BW'(BURST_MAX)) begin
                    tx_data   <= lane[owner];
                    last_q    <= req_last[owner];
                    burst_cnt <= burst_cnt + 1'b1;
                    tx_start  <= 1'b1;
                    state     <= LAUNCH;
                end else begin
                    grant <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of byte requesters sharing one UART transmitter.
REQ-002 Parameter BURST_MAX, default 4, maximum consecutive bytes per grant.
REQ-003 Parameter TIMEOUT, default 15, baud_clk cycles allowed for tx_busy to rise after tx_start.
REQ-004 The block SHALL use reset rst, asynchronous, active-high, and clock baud_clk.
REQ-005 Port list SHALL be exactly as follows:
  baud_clk  in  1  bit-rate clock, all state on rising edge
  rst  in  1  asynchronous active-high reset
  req  in  NREQ  per-requester byte-pending, level
  req_data  in  8*NREQ  byte lanes; lane i = bits [8i+7:8i]
  req_last  in  NREQ  lane i byte ends its burst
  ack  out  NREQ  one-hot, one-cycle pulse: byte i fully transmitted
  grant  out  NREQ  one-hot owner of transmitter, 0 when idle
  tx_start  out  1  one-cycle launch pulse to transmitter
  tx_data  out  8  byte to transmit, stable from tx_start until ack
  tx_busy  in  1  transmitter frame in progress
  busy  out  1  grant != 0
  timeout_err  out  1  sticky: transmitter failed to start
  err_clr  in  1  clears timeout_err

Function
REQ-006 FSM states SHALL be IDLE, GRANT, LAUNCH, WAIT_BUSY, WAIT_DONE, ACK, EVAL.
REQ-007 IDLE: when req != 0, winner = first set req bit searching from (last_winner+1) mod NREQ upward with wrap; go to GRANT.
REQ-008 GRANT: grant = one-hot winner, tx_data and req_last[winner] latched, burst_cnt = 1, last_winner = winner; go to LAUNCH.
REQ-009 LAUNCH: tx_start = 1 for exactly this cycle; timer cleared; go to WAIT_BUSY.
REQ-010 WAIT_BUSY: tx_busy = 1 -> WAIT_DONE; else timer increments; timer == TIMEOUT with tx_busy = 0 -> timeout_err set, grant cleared, no ack, IDLE.
REQ-011 WAIT_DONE: tx_busy = 0 -> ACK.
REQ-012 ACK: ack[owner] = 1 this cycle only; go to EVAL.
REQ-013 EVAL: req[owner] = 1 and latched last = 0 and burst_cnt < BURST_MAX -> latch new tx_data/last, burst_cnt+1, LAUNCH; else grant = 0, IDLE.
REQ-014 Requesters SHALL update lane data/req/last on the edge ending ACK; EVAL samples post-update values.
REQ-015 Deassertion of req[owner] during LAUNCH/WAIT_* SHALL NOT abort the byte; ack still issued.
REQ-016 Requests from non-owners SHALL be ignored until IDLE; no pre-emption.
REQ-017 Latency IDLE-with-req to tx_start SHALL be 2 cycles; ack to next tx_start within burst 2 cycles.
REQ-018 timeout_err SHALL remain 1 until err_clr; set and err_clr in same cycle -> set wins.
REQ-019 timeout_err SHALL NOT block arbitration.
REQ-020 tx_data SHALL change only in GRANT or EVAL.
REQ-021 busy SHALL equal OR-reduction of grant.

Reset
REQ-022 rst SHALL force IDLE, grant = 0, ack = 0, tx_start = 0, tx_data = 8'h00, busy = 0, timeout_err = 0, burst_cnt = 0, timer = 0, last_winner = NREQ-1.
REQ-023 rst mid-transfer SHALL drop tx_start/grant immediately with no ack for the in-flight byte.

Structure
REQ-024 FSM state encodings and default parameter values SHALL reside in shared package uart_pkg.
REQ-025 Round-robin selection SHALL be sub-module rr_pick (req, last_winner -> one-hot winner), combinational.
REQ-026 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-027 After reset, req = 4'b0101, lanes 0x41/0x42 on 0/2, last = 1, tx_busy model 10 cycles -> lane0 sent first (tx_data 0x41, tx_start cycle 2), then lane2 (0x42).
REQ-028 req0 burst of 6 bytes 0x10..0x15, last only on 0x15 -> grant held 4 bytes (0x10..0x13), released, regranted for 0x14, 0x15 when no other req.
REQ-029 req = 4'b1111 continuously, last = 1 -> grant order 0,1,2,3,0 with ack pulses one cycle each.
REQ-030 tx_busy tied 0 -> after 15 WAIT_BUSY cycles timeout_err = 1, no ack, grant 0; err_clr pulse -> 0; simultaneous set and err_clr -> stays 1.
REQ-031 rst asserted during WAIT_DONE of lane1 -> same cycle grant = 0, tx_start = 0, no ack; after release req1 regranted first only if round-robin pointer allows (last_winner = 3 -> lane0 priority).
REQ-032 req1 drops during WAIT_BUSY -> byte completes, ack[1] pulses, EVAL returns to IDLE.
